// File: rtl/aes_shiftrows_stream.sv
// AES ShiftRows / InvShiftRows applied to a streamed state block, with a
// two-entry (output + skid) ready/valid buffer and a completion counter.
module aes_shiftrows_stream #(
  parameter  int NB    = 4,
  parameter  int CNT_W = 16,
  localparam int W     = 32 * NB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     data_in,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     data_out,
  output logic [CNT_W-1:0] blk_count,
  output logic             mode_err
);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_nb_check
    $error("aes_shiftrows_stream: NB must be 4, 6 or 8");
  end
  if (CNT_W < 8 || CNT_W > 32) begin : g_cnt_check
    $error("aes_shiftrows_stream: CNT_W must be in 8..32");
  end

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_SHIFT = 2'b01,
    MODE_INV   = 2'b10,
    MODE_ILL   = 2'b11
  } mode_t;

  localparam int unsigned NBU = NB;

  mode_t          mode_e;
  logic [W-1:0]   xf;
  logic [W-1:0]   out_data;
  logic [W-1:0]   skid_data;
  logic           skid_valid;
  logic           accept;
  logic           complete;

  // Rijndael offsets: rows 2 and 3 move one further for 256-bit blocks.
  function automatic int unsigned row_shift(input int unsigned r);
    if (NBU == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  assign mode_e   = mode_t'(mode);
  assign accept   = in_valid && in_ready;
  assign complete = out_valid && out_ready;
  assign data_out = out_data;

  always_comb begin
    int unsigned src;
    src = 0;
    xf  = data_in;
    if (mode_e == MODE_SHIFT || mode_e == MODE_INV) begin
      for (int unsigned r = 0; r < 4; r++) begin
        for (int unsigned c = 0; c < NBU; c++) begin
          if (mode_e == MODE_SHIFT) src = (c + row_shift(r)) % NBU;
          else                      src = (c + NBU - row_shift(r)) % NBU;
          xf[8*(4*c+r) +: 8] = data_in[8*(4*src+r) +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
      blk_count  <= '0;
      mode_err   <= 1'b0;
    end else begin
      in_ready <= !skid_valid;
      if (complete) blk_count <= blk_count + CNT_W'(1);
      if (accept && mode_e == MODE_ILL) mode_err <= 1'b1;
      // in_ready tracks !skid_valid, so an accept never coincides with a full skid
      if (complete && skid_valid) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else if (accept && (!out_valid || complete)) begin
        out_data  <= xf;
        out_valid <= 1'b1;
      end else if (accept) begin
        skid_data  <= xf;
        skid_valid <= 1'b1;
        in_ready   <= 1'b0;
      end else if (complete) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/aes_shiftrows_stream.md
AES_SHIFTROWS_STREAM -- requirements
Module: aes_shiftrows_stream

Interface
REQ-001 Parameter NB, default 4, state columns; legal values 4, 6, 8; any other value SHALL be an elaboration error.
REQ-002 Parameter CNT_W, default 16, block counter width; legal range 8..32.
REQ-003 Derived W = 32*NB, data width in bits.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  data_in and mode are valid this cycle.
REQ-007 in_ready  output  1  block can accept an input this cycle.
REQ-008 data_in  input  W  state bytes; byte k = 4c+r occupies data_in[8k+7:8k] (row r, column c).
REQ-009 mode  input  2  00 pass, 01 ShiftRows, 10 InvShiftRows, 11 illegal.
REQ-010 out_valid  output  1  data_out holds a transformed block.
REQ-011 out_ready  input  1  consumer accepts data_out this cycle.
REQ-012 data_out  output  W  transformed state, same byte mapping as data_in.
REQ-013 blk_count  output  CNT_W  number of completed output handshakes.
REQ-014 mode_err  output  1  sticky flag: an illegal mode was accepted.

Function
REQ-015 Row shift offsets s0..s3 SHALL be 0,1,2,3 for NB=4 and NB=6, and 0,1,3,4 for NB=8.
REQ-016 ShiftRows: out[r][c] = in[r][(c+s_r) mod NB].
REQ-017 InvShiftRows: out[r][c] = in[r][(c-s_r) mod NB].
REQ-018 Pass mode and illegal mode SHALL both give out = in; mode is sampled with its data on acceptance.
REQ-019 An input is accepted when in_valid && in_ready. The transform is applied combinationally before storage.
REQ-020 An output is completed when out_valid && out_ready.
REQ-021 Storage SHALL be one output register plus one skid register.
REQ-022 in_ready SHALL be registered and equal to NOT skid_valid.
REQ-023 Accept routing: if the output register is empty or is completing this cycle, and the skid is empty, the accepted block loads the output register. Otherwise the accepted block loads the skid.
REQ-024 On completion with the skid full, the output register SHALL load from the skid and the skid SHALL clear in the same cycle.
REQ-025 On completion with the skid empty and no accept, out_valid SHALL fall next cycle.
REQ-026 Latency: an accepted block SHALL appear on data_out the cycle after acceptance when the pipe is empty.
REQ-027 Throughput: one block per cycle with out_ready held high; no bubbles.
REQ-028 While out_valid && !out_ready, data_out SHALL be stable.
REQ-029 Order SHALL be preserved, with no loss or duplication.
REQ-030 blk_count SHALL increment by 1 on each completion and wrap from 2^CNT_W-1 to 0.
REQ-031 mode_err SHALL set on acceptance of mode 11 and stay set until reset.
REQ-032 Inputs presented while in_ready=0 SHALL be ignored.

Reset
REQ-033 While rst_n=0: out_valid=0, skid empty, in_ready=0, data_out=0, blk_count=0, mode_err=0.
REQ-034 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-035 Reset asserted mid-transfer SHALL discard all held blocks immediately, with no output handshake.

Verification
REQ-036 NB=4, mode 01, bytes k=0..15 = 00..0F -> data_out bytes 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B, one cycle later.
REQ-037 NB=4, mode 10, on the REQ-036 output -> bytes 00..0F. Also, mode 01 on FIPS-197 round-1 bytes D4 27 11 AE E0 BF 98 F1 B8 B4 5D E5 1E 41 52 30 -> D4 BF 5D 30 E0 B4 52 AE B8 41 11 F1 1E 27 98 E5.
REQ-038 NB=8, mode 01, bytes k=0..31 = k -> byte 4c+2 = in byte 4((c+3) mod 8)+2, byte 4c+3 = in byte 4((c+4) mod 8)+3; mode 10 round-trips. NB=6 checked the same way.
REQ-039 Backpressure: out_ready=0 for 3 cycles while in_valid=1 -> in_ready falls after 2 accepts. On release: 2 blocks in order, data stable while stalled, blk_count +2.
REQ-040 CNT_W=8, 257 completions -> blk_count=1. One mode-11 block -> output equals input, mode_err=1 until reset.
REQ-041 rst_n pulsed low with both registers full -> out_valid=0 immediately, no handshake, in_ready=1 one cycle after release.
